// File: rtl/sseg_scan_if.sv
// Host-side and pin-side signal bundle for sseg_scan_ctrl.
// master = user logic driving display data, slave = the scan controller.
interface sseg_scan_if;
  logic        load;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic [3:0]  brightness;
  logic        update_ack;
  logic        frame_done;
  logic [6:0]  sseg_digit;
  logic        sseg_dp;
  logic [3:0]  sseg_selectn;

  modport master (
    output load, value_in, dp_in, digit_en, brightness,
    input  update_ack, frame_done, sseg_digit, sseg_dp, sseg_selectn
  );

  modport slave (
    input  load, value_in, dp_in, digit_en, brightness,
    output update_ack, frame_done, sseg_digit, sseg_dp, sseg_selectn
  );
endinterface

// File: rtl/sseg_scan_ctrl.sv
// Time-multiplexed 4-digit seven-segment scan controller with frame-synchronous
// double buffering. Define SSEG_BRIGHTNESS_EN to add 16-phase PWM anode dimming.
module sseg_scan_ctrl #(
  parameter int DIGIT_TICKS = 100000,
  parameter int BLANK_TICKS = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  sseg_scan_if.slave bus
);
  localparam int MAX_TICKS = (DIGIT_TICKS > BLANK_TICKS) ? DIGIT_TICKS : BLANK_TICKS;
  localparam int CNT_W     = $clog2(MAX_TICKS + 1);
  localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_TICKS - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_TICKS - 1);

  typedef enum logic [0:0] {ST_BLANK = 1'b0, ST_DRIVE = 1'b1} state_t;

  function automatic logic [6:0] hexdec(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  function automatic logic [3:0] anode_sel(input logic [1:0] i, input logic en, input logic lit);
    logic [3:0] sel;
    sel = 4'hF;
    if (en && lit) begin
      sel[i] = 1'b0;
    end else begin
      sel = 4'hF;
    end
    return sel;
  endfunction

  state_t           state_r;
  logic [1:0]       idx_r;
  logic [CNT_W-1:0] cnt_r;
  logic [15:0]      pend_value_r, shadow_value_r;
  logic [3:0]       pend_dp_r, shadow_dp_r;
  logic [3:0]       pend_en_r, shadow_en_r;
  logic             pend_valid_r;
  logic [3:0]       sel_r;
  logic [6:0]       digit_r;
  logic             dp_r;
  logic             ack_r;
  logic             done_r;
  logic             frame_edge_s;
  logic             lit_nxt_s;
`ifdef SSEG_BRIGHTNESS_EN
  logic [3:0]       pend_bri_r, shadow_bri_r;
  logic [3:0]       phase_r;
  logic [3:0]       phase_nxt_s;
`else
  logic             unused_brightness_s;
  assign unused_brightness_s = ^bus.brightness;
`endif

  // Frame boundary detect and next-cycle anode gating.
  always_comb begin
    frame_edge_s = (state_r == ST_DRIVE) && (cnt_r == DIGIT_LAST) && (idx_r == 2'd3);
`ifdef SSEG_BRIGHTNESS_EN
    phase_nxt_s = phase_r + 4'd1;
    lit_nxt_s   = (phase_nxt_s <= shadow_bri_r);
`else
    lit_nxt_s   = 1'b1;
`endif
  end

  // Scan FSM: slot timing, digit index and registered pin outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_BLANK;
      idx_r   <= 2'd0;
      cnt_r   <= '0;
      sel_r   <= 4'hF;
      digit_r <= 7'h7F;
      dp_r    <= 1'b1;
      ack_r   <= 1'b0;
      done_r  <= 1'b0;
`ifdef SSEG_BRIGHTNESS_EN
      phase_r <= 4'd0;
`endif
    end else begin
      ack_r  <= frame_edge_s & pend_valid_r;
      done_r <= frame_edge_s;
      case (state_r)
        ST_BLANK: begin
          if (cnt_r == BLANK_LAST) begin
            // Phase 0 is always lit, so the entry edge never needs gating.
            state_r <= ST_DRIVE;
            cnt_r   <= '0;
            sel_r   <= anode_sel(idx_r, shadow_en_r[idx_r], 1'b1);
            digit_r <= hexdec(shadow_value_r[{idx_r, 2'b00} +: 4]);
            dp_r    <= ~shadow_dp_r[idx_r];
`ifdef SSEG_BRIGHTNESS_EN
            phase_r <= 4'd0;
`endif
          end else begin
            cnt_r   <= cnt_r + CNT_W'(1);
            sel_r   <= 4'hF;
            digit_r <= 7'h7F;
            dp_r    <= 1'b1;
          end
        end
        ST_DRIVE: begin
          if (cnt_r == DIGIT_LAST) begin
            state_r <= ST_BLANK;
            cnt_r   <= '0;
            idx_r   <= idx_r + 2'd1;
            sel_r   <= 4'hF;
            digit_r <= 7'h7F;
            dp_r    <= 1'b1;
          end else begin
            cnt_r   <= cnt_r + CNT_W'(1);
            sel_r   <= anode_sel(idx_r, shadow_en_r[idx_r], lit_nxt_s);
`ifdef SSEG_BRIGHTNESS_EN
            phase_r <= phase_nxt_s;
`endif
          end
        end
        default: begin
          state_r <= ST_BLANK;
          cnt_r   <= '0;
          sel_r   <= 4'hF;
          digit_r <= 7'h7F;
          dp_r    <= 1'b1;
        end
      endcase
    end
  end

  // Pending capture; shadow is promoted only on the frame edge, using pre-edge pending.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_value_r   <= 16'h0000;
      pend_dp_r      <= 4'h0;
      pend_en_r      <= 4'h0;
      pend_valid_r   <= 1'b0;
      shadow_value_r <= 16'h0000;
      shadow_dp_r    <= 4'h0;
      shadow_en_r    <= 4'h0;
`ifdef SSEG_BRIGHTNESS_EN
      pend_bri_r     <= 4'h0;
      shadow_bri_r   <= 4'h0;
`endif
    end else begin
      if (frame_edge_s && pend_valid_r) begin
        shadow_value_r <= pend_value_r;
        shadow_dp_r    <= pend_dp_r;
        shadow_en_r    <= pend_en_r;
`ifdef SSEG_BRIGHTNESS_EN
        shadow_bri_r   <= pend_bri_r;
`endif
      end
      if (bus.load) begin
        pend_value_r <= bus.value_in;
        pend_dp_r    <= bus.dp_in;
        pend_en_r    <= bus.digit_en;
        pend_valid_r <= 1'b1;
`ifdef SSEG_BRIGHTNESS_EN
        pend_bri_r   <= bus.brightness;
`endif
      end else if (frame_edge_s) begin
        pend_valid_r <= 1'b0;
      end
    end
  end

  assign bus.sseg_selectn = sel_r;
  assign bus.sseg_digit   = digit_r;
  assign bus.sseg_dp      = dp_r;
  assign bus.update_ack   = ack_r;
  assign bus.frame_done   = done_r;
endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Randomized bench for sseg_scan_ctrl; expected pins come from a time-position
// model (cycle index within the frame) plus a pending/shadow buffer model.
module tb_sseg_scan_ctrl;
  localparam int DT    = 4;
  localparam int BT    = 2;
  localparam int SLOT  = DT + BT;
  localparam int FRAME = 4 * SLOT;
  localparam logic [6:0] HEX_TBL [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic clk;
  logic rst_n;
  sseg_scan_if bus_if();

  sseg_scan_ctrl #(.DIGIT_TICKS(DT), .BLANK_TICKS(BT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int check_cnt;
  int err_cnt;
  int k;
  logic        m_pv;
  logic [15:0] m_pend_val, m_sh_val;
  logic [3:0]  m_pend_dp, m_sh_dp, m_pend_en, m_sh_en, m_pend_bri, m_sh_bri;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    check_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h (cycle %0d in run)", tag, obs, exp, k);
    end
  endtask

  task automatic step(input logic rst, input logic ld, input logic [15:0] v,
                      input logic [3:0] d, input logic [3:0] e, input logic [3:0] b);
    logic [3:0] e_sel;
    logic [6:0] e_dig;
    logic       e_dp, e_ack, e_done, lit;
    logic [3:0] nib;
    int p, s, q;
    rst_n = rst;
    bus_if.load = ld;
    bus_if.value_in = v;
    bus_if.dp_in = d;
    bus_if.digit_en = e;
    bus_if.brightness = b;
    @(posedge clk);
    e_ack = 1'b0;
    e_done = 1'b0;
    if (!rst) begin
      k = 0;
      m_pv = 1'b0;
      m_pend_val = 16'h0; m_pend_dp = 4'h0; m_pend_en = 4'h0; m_pend_bri = 4'h0;
      m_sh_val = 16'h0;   m_sh_dp = 4'h0;   m_sh_en = 4'h0;   m_sh_bri = 4'h0;
    end else begin
      k++;
      if (k % FRAME == 0) begin
        e_done = 1'b1;
        if (m_pv) begin
          m_sh_val = m_pend_val; m_sh_dp = m_pend_dp; m_sh_en = m_pend_en; m_sh_bri = m_pend_bri;
          m_pv = 1'b0;
          e_ack = 1'b1;
        end
      end
      if (ld) begin
        m_pend_val = v; m_pend_dp = d; m_pend_en = e; m_pend_bri = b;
        m_pv = 1'b1;
      end
    end
    p = k % FRAME;
    s = p / SLOT;
    q = p % SLOT;
    if (q < BT) begin
      e_sel = 4'hF;
      e_dig = 7'h7F;
      e_dp  = 1'b1;
    end else begin
      nib   = 4'((m_sh_val >> (4 * s)) & 16'h000F);
      e_dig = HEX_TBL[nib];
      e_dp  = ~m_sh_dp[s];
      lit   = 1'b1;
`ifdef SSEG_BRIGHTNESS_EN
      lit   = ((q - BT) <= int'(m_sh_bri));
`endif
      e_sel = (m_sh_en[s] && lit) ? ~(4'b0001 << s) : 4'hF;
    end
    #1;
    check_val("selectn",    16'(bus_if.sseg_selectn), 16'(e_sel));
    check_val("digit",      16'(bus_if.sseg_digit),   16'(e_dig));
    check_val("dp",         16'(bus_if.sseg_dp),      16'(e_dp));
    check_val("update_ack", 16'(bus_if.update_ack),   16'(e_ack));
    check_val("frame_done", 16'(bus_if.frame_done),   16'(e_done));
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 16'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
  endtask

  initial begin
    check_cnt = 0;
    err_cnt = 0;
    k = 0;
    rst_n = 1'b0;
    bus_if.load = 1'b0;
    bus_if.value_in = 16'h0;
    bus_if.dp_in = 4'h0;
    bus_if.digit_en = 4'h0;
    bus_if.brightness = 4'h0;

    repeat (3) step(1'b0, 1'b0, 16'h0, 4'h0, 4'h0, 4'h0);

    // Basic frame: digits 8, F., 2, 1 after the first boundary.
    step(1'b1, 1'b1, 16'h12F8, 4'b0010, 4'hF, 4'($urandom_range(0, 15)));
    repeat (2 * FRAME) idle();

    // Two loads mid-frame: the last one wins at the next boundary.
    while (k % FRAME != 8) idle();
    step(1'b1, 1'b1, 16'hAAAA, 4'hF, 4'hF, 4'd15);
    idle();
    step(1'b1, 1'b1, 16'h0000, 4'h0, 4'hF, 4'd3);
    repeat (2 * FRAME) idle();

    // Partial enable; load lands exactly on a boundary edge.
    while (k % FRAME != FRAME - 1) idle();
    step(1'b1, 1'b1, 16'h5A3C, 4'b1001, 4'b0101, 4'd7);
    repeat (3 * FRAME) idle();

    // Reset pulse inside the digit-2 drive slot.
    while (k % FRAME != 2 * SLOT + BT + 1) idle();
    step(1'b0, 1'b0, 16'h0, 4'h0, 4'h0, 4'h0);
    repeat (FRAME + 4) idle();

    // Random traffic with occasional resets.
    repeat (3000) begin
      step(($urandom_range(0, 499) != 0), ($urandom_range(0, 9) == 0),
           16'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
    $finish;
  end
endmodule
